// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the X stage.
// Radix-2^MUL_STEP shift-add multiply, radix-2 restoring divide, sign fixup on the last iteration.
module mips_muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_x,
    input  logic [WIDTH-1:0] op_y,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int N_MUL = WIDTH / MUL_STEP;
    localparam int N_DIV = WIDTH;
    localparam int CW    = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(N_MUL - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(N_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

    state_t               state_reg;
    logic [CW-1:0]        count_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic                 dz_reg;
    logic [WIDTH-1:0]     hi_reg;
    logic [WIDTH-1:0]     lo_reg;
    // MUL: {accumulator high half, remaining multiplier bits}; DIV: {remainder, quotient}
    logic [2*WIDTH-1:0]   work_reg;
    logic [WIDTH-1:0]     operand_reg;
    logic                 neg_q_reg;
    logic                 neg_r_reg;

    logic                 is_signed;
    logic                 x_neg;
    logic                 y_neg;
    logic [WIDTH-1:0]     x_abs;
    logic [WIDTH-1:0]     y_abs;

    always_comb begin
        is_signed = ~op[0];
        x_neg     = is_signed & op_x[WIDTH-1];
        y_neg     = is_signed & op_y[WIDTH-1];
        x_abs     = x_neg ? -op_x : op_x;
        y_abs     = y_neg ? -op_y : op_y;
    end

    // One shifted copy of the multiplicand per multiplier bit retired this cycle.
    logic [WIDTH+MUL_STEP-1:0] pp_terms [MUL_STEP];

    genvar gi;
    generate
        for (gi = 0; gi < MUL_STEP; gi++) begin : g_pp
            assign pp_terms[gi] = work_reg[gi]
                ? ({{MUL_STEP{1'b0}}, operand_reg} << gi)
                : '0;
        end
    endgenerate

    logic [WIDTH+MUL_STEP-1:0] pp_sum;
    logic [WIDTH+MUL_STEP-1:0] mul_sum;
    logic [2*WIDTH-1:0]        mul_next;
    logic [2*WIDTH-1:0]        mul_res;

    always_comb begin
        pp_sum = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            pp_sum = pp_sum + pp_terms[i];
        end
        mul_sum  = {{MUL_STEP{1'b0}}, work_reg[2*WIDTH-1:WIDTH]} + pp_sum;
        mul_next = {mul_sum, work_reg[WIDTH-1:MUL_STEP]};
        mul_res  = neg_q_reg ? -mul_next : mul_next;
    end

    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   div_quo;
    logic [WIDTH-1:0]   div_rem;
    logic               div_by_zero;
    logic [WIDTH-1:0]   div_lo;
    logic [WIDTH-1:0]   div_hi;

    always_comb begin
        div_diff = {1'b0, work_reg[2*WIDTH-1:WIDTH-1]} - {2'b00, operand_reg};
        if (div_diff[WIDTH+1]) begin
            div_next = {work_reg[2*WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_diff[WIDTH-1:0], work_reg[WIDTH-2:0], 1'b1};
        end
        div_quo     = div_next[WIDTH-1:0];
        div_rem     = div_next[2*WIDTH-1:WIDTH];
        div_by_zero = (operand_reg == '0);
        // A zero divisor shifts the dividend straight into the remainder, so the
        // sign fixup restores the original op_x; only the quotient needs forcing.
        div_lo      = div_by_zero ? '1 : (neg_q_reg ? -div_quo : div_quo);
        div_hi      = neg_r_reg ? -div_rem : div_rem;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            dz_reg      <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            work_reg    <= '0;
            operand_reg <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
        end else if (en) begin
            done_reg <= 1'b0;
            dz_reg   <= 1'b0;
            if (flush) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            case (op)
                                3'd0, 3'd1: begin
                                    state_reg   <= MUL;
                                    busy_reg    <= 1'b1;
                                    count_reg   <= '0;
                                    work_reg    <= {{WIDTH{1'b0}}, y_abs};
                                    operand_reg <= x_abs;
                                    neg_q_reg   <= x_neg ^ y_neg;
                                    neg_r_reg   <= 1'b0;
                                end
                                3'd2, 3'd3: begin
                                    state_reg   <= DIV;
                                    busy_reg    <= 1'b1;
                                    count_reg   <= '0;
                                    work_reg    <= {{WIDTH{1'b0}}, x_abs};
                                    operand_reg <= y_abs;
                                    neg_q_reg   <= x_neg ^ y_neg;
                                    neg_r_reg   <= x_neg;
                                end
                                3'd4:    hi_reg <= op_x;
                                3'd5:    lo_reg <= op_x;
                                default: ;
                            endcase
                        end
                    end
                    MUL: begin
                        work_reg  <= mul_next;
                        count_reg <= count_reg + CW'(1);
                        if (count_reg == MUL_LAST) begin
                            hi_reg    <= mul_res[2*WIDTH-1:WIDTH];
                            lo_reg    <= mul_res[WIDTH-1:0];
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= IDLE;
                        end
                    end
                    DIV: begin
                        work_reg  <= div_next;
                        count_reg <= count_reg + CW'(1);
                        if (count_reg == DIV_LAST) begin
                            hi_reg    <= div_hi;
                            lo_reg    <= div_lo;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            dz_reg    <= div_by_zero;
                            state_reg <= IDLE;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign div_zero = dz_reg;
    assign hi       = hi_reg;
    assign lo       = lo_reg;

endmodule
